// File: rtl/dm_clr_if.sv
// Load/store bus for the dm_clr data memory.
// The controller side drives the master modport; the memory uses the slave modport.
interface dm_clr_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic              i_clear_req;
    logic [AW-1:0]     i_mem_adr;
    logic              i_read_en;
    logic              i_write_en;
    logic [DW/8-1:0]   i_byte_en;
    logic [DW-1:0]     i_dat_in;
    logic [DW-1:0]     o_dat_out;
    logic              o_busy;
    logic              o_clr_done;

    modport master (
        output i_clear_req, i_mem_adr, i_read_en, i_write_en, i_byte_en, i_dat_in,
        input  o_dat_out, o_busy, o_clr_done
    );

    modport slave (
        input  i_clear_req, i_mem_adr, i_read_en, i_write_en, i_byte_en, i_dat_in,
        output o_dat_out, o_busy, o_clr_done
    );
endinterface

// File: rtl/dm_clr.sv
// Data memory with byte-lane writes and a clear engine that zeroes every word after reset or on request.
// Optional macro DM_RDREG_EN: registered reads with one cycle of latency (default: combinational reads).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | user loads/stores serviced; ClearReq starts a sweep
// S_CLEAR | one word zeroed per cycle from address 0 up; user access ignored
module dm_clr #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic     clk,
    input  logic     Reset,
    dm_clr_if.slave  bus
);
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_adr;
    logic [AW-1:0]   w_clr_adr_nxt;
    logic            r_clr_done;
    logic            w_clr_done_nxt;
    logic            w_clr_we;
    logic            w_user_we;
    logic            w_busy;
    logic [DW-1:0]   w_rd_data;
    logic [DW-1:0]   r_core [DEPTH];

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state    <= S_CLEAR;
            r_clr_adr  <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_adr  <= w_clr_adr_nxt;
            r_clr_done <= w_clr_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_adr_nxt  = r_clr_adr;
        w_clr_done_nxt = 1'b0;
        w_clr_we       = 1'b0;
        w_user_we      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A store in the same cycle as ClearReq is dropped.
                if (bus.i_clear_req) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_adr_nxt = '0;
                end else if (bus.i_write_en) begin
                    w_user_we = 1'b1;
                end
            end
            S_CLEAR: begin
                w_clr_we      = 1'b1;
                w_clr_adr_nxt = r_clr_adr + 1'b1;
                if (r_clr_adr == {AW{1'b1}}) begin
                    w_state_nxt    = S_IDLE;
                    w_clr_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    // Core has no reset of its own; a sweep always follows reset.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            if (w_clr_we) begin
                r_core[r_clr_adr] <= '0;
            end else if (w_user_we) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.i_byte_en[i]) begin
                        r_core[bus.i_mem_adr][8*i +: 8] <= bus.i_dat_in[8*i +: 8];
                    end
                end
            end
        end
    end

    assign w_busy     = (r_state == S_CLEAR);
    assign w_rd_data  = (bus.i_read_en && !w_busy) ? r_core[bus.i_mem_adr] : '0;
    assign bus.o_busy     = w_busy;
    assign bus.o_clr_done = r_clr_done;

`ifdef DM_RDREG_EN
    logic [DW-1:0] r_dat_out;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_dat_out <= '0;
        end else begin
            r_dat_out <= w_rd_data;
        end
    end

    assign bus.o_dat_out = r_dat_out;
`else
    assign bus.o_dat_out = w_rd_data;
`endif
endmodule

// File: tb/tb_dm_clr.sv
// Bench for dm_clr with AW=4, DW=32; read data checked against an expected-value queue.
module tb_dm_clr;
    localparam int AW = 4;
    localparam int DW = 32;
`ifdef DM_RDREG_EN
    localparam int RD_LAT = 1;
`else
    localparam int RD_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    dm_clr_if #(.AW(AW), .DW(DW)) bus ();

    dm_clr #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        int          due;
        logic [31:0] val;
        string       tag;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [3:0]  adr;
        logic [31:0] din;
        logic        re;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            sb_t e;
            e = sb_q.pop_front();
            if (e.due != cyc) chk({e.tag, "_late"}, 32'(e.due), 32'(cyc));
            else chk(e.tag, bus.o_dat_out, e.val);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cr, input logic we, input logic [3:0] be,
                         input logic [3:0] adr, input logic [31:0] din, input logic re);
        bus.i_clear_req = cr;
        bus.i_write_en  = we;
        bus.i_byte_en   = be;
        bus.i_mem_adr   = adr;
        bus.i_dat_in    = din;
        bus.i_read_en   = re;
    endtask

    task automatic push_exp(input logic [31:0] v, input string tag);
        sb_q.push_back('{cyc + RD_LAT, v, tag});
    endtask

    task automatic rd(input logic [3:0] adr, input logic [31:0] exp, input string tag);
        drive(1'b0, 1'b0, 4'h0, adr, 32'h0, 1'b1);
        push_exp(exp, tag);
        tick();
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] din, input logic [3:0] be);
        drive(1'b0, 1'b1, be, adr, din, 1'b0);
        tick();
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Counts busy cycles to the fall, then ClrDone pulses over the sweep plus one idle cycle.
    task automatic measure_sweep(output int nb, output int nd);
        bit done;
        nb = 0;
        nd = 0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.o_clr_done) nd++;
            if (bus.o_busy) nb++;
            else begin
                @(negedge clk);
                if (bus.o_clr_done) nd++;
                done = 1;
            end
        end
        if (!done) nb = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nb, nd;

        vecs[0]  = '{1'b1, 4'hF, 4'd5,  32'hAABBCCDD, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 4'h5, 4'd5,  32'h11223344, 1'b1, 32'hAABBCCDD};
        vecs[2]  = '{1'b0, 4'h0, 4'd5,  32'h0,        1'b1, 32'hAA22CC44};
        vecs[3]  = '{1'b1, 4'h8, 4'd0,  32'h12345678, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 32'h12000000};
        vecs[5]  = '{1'b1, 4'h0, 4'd15, 32'hFFFFFFFF, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 4'h0, 4'd15, 32'h0,        1'b1, 32'h0};
        vecs[7]  = '{1'b1, 4'h6, 4'd15, 32'hCAFEBABE, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 4'h0, 4'd15, 32'h0,        1'b1, 32'h00FEBA00};
        vecs[9]  = '{1'b0, 4'h0, 4'd5,  32'h0,        1'b0, 32'h0};
        vecs[10] = '{1'b1, 4'hF, 4'd7,  32'h0000003C, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 4'hF, 4'd7,  32'h00000099, 1'b1, 32'h0000003C};
        vecs[12] = '{1'b0, 4'h0, 4'd7,  32'h0,        1'b1, 32'h00000099};

        // Reset held for two edges, with a read presented throughout.
        drive(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.o_busy), 32'd1);
        chk("rst_done", 32'(bus.o_clr_done), 32'd0);
        chk("rst_dout", bus.o_dat_out, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        measure_sweep(nb, nd);
        chk("rst_sweep_len", 32'(nb), 32'd16);
        chk("rst_sweep_done", 32'(nd), 32'd1);
        tick();
        for (int a = 0; a < 16; a++) rd(4'(a), 32'h0, "post_rst_read");
        idle(2);

        for (int i = 0; i < 13; i++) begin
            drive(1'b0, vecs[i].we, vecs[i].be, vecs[i].adr, vecs[i].din, vecs[i].re);
            push_exp(vecs[i].exp, $sformatf("vec%0d", i));
            tick();
        end
        idle(2);

        // ClearReq with a concurrent store; later a store and second ClearReq mid-sweep.
        drive(1'b1, 1'b1, 4'hF, 4'd2, 32'h0000005A, 1'b0);
        tick();
        for (int j = 1; j <= 11; j++) begin
            if (j == 11) begin
                drive(1'b1, 1'b1, 4'hF, 4'd3, 32'h000000FF, 1'b1);
                push_exp(32'h0, "busy_read");
            end else begin
                drive(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
            end
            @(negedge clk);
            chk($sformatf("clr_busy%0d", j), 32'(bus.o_busy), 32'd1);
            tick();
        end
        drive(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
        measure_sweep(nb, nd);
        chk("clr_rest_len", 32'(nb), 32'd5);
        chk("clr_done", 32'(nd), 32'd1);
        tick();
        rd(4'd2, 32'h0, "clr_adr2");
        rd(4'd3, 32'h0, "clr_adr3");
        rd(4'd5, 32'h0, "clr_adr5");
        rd(4'd7, 32'h0, "clr_adr7");
        idle(1);

        // Reset landing at sweep address 9 restarts the full sweep.
        wr(4'd12, 32'h00000077, 4'hF);
        rd(4'd12, 32'h00000077, "pre_adr12");
        drive(1'b1, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
        tick();
        idle(9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        measure_sweep(nb, nd);
        chk("mid_rst_len", 32'(nb), 32'd16);
        chk("mid_rst_done", 32'(nd), 32'd1);
        tick();
        rd(4'd12, 32'h0, "mid_rst_adr12");
        wr(4'd9, 32'h01020304, 4'h3);
        rd(4'd9, 32'h00000304, "post_adr9");
        idle(3);

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
